// File: rtl/spi_slave_gen2.sv
// SPI slave frame engine: 2-bit command + DATA_W payload per frame, one bit per clk while
// i_ss_n is low. Supports write, read-address and read-data frames with a tx handshake for
// read-back and abort detection on early slave-select release.
module spi_slave_gen2 #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic [DATA_W+1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_busy,
  output logic              o_frame_err
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData,
    StTxShift
  } state_e;

  state_e              r_state, w_state_d;
  logic                r_rd_pending, w_rd_pending_d;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_d;
  // Holds all but the newest frame bit; the newest bit comes straight from i_mosi.
  logic [FRAME_W-2:0]  r_rx_sr, w_rx_sr_d;
  logic [DATA_W-1:0]   r_tx_sr, w_tx_sr_d;
  logic                r_miso, w_miso_d;
  logic [FRAME_W-1:0]  r_rx_data, w_rx_data_d;
  logic                r_rx_valid, w_rx_valid_d;
  logic                r_frame_err, w_frame_err_d;

  logic [FRAME_W-1:0]  w_frame;
  logic [FRAME_W-1:0]  w_rx_word;

  function automatic logic [DATA_W-1:0] reverse_bits(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

  // Frame as it would look with the current MOSI bit shifted in; payload always MSB-aligned.
  always_comb begin
    w_frame   = {r_rx_sr, i_mosi};
    w_rx_word = w_frame;
    if (LSB_FIRST) begin
      w_rx_word[DATA_W-1:0] = reverse_bits(w_frame[DATA_W-1:0]);
    end
  end

  // Next-state and datapath update for the frame FSM.
  always_comb begin
    w_state_d      = r_state;
    w_rd_pending_d = r_rd_pending;
    w_bit_cnt_d    = r_bit_cnt;
    w_rx_sr_d      = r_rx_sr;
    w_tx_sr_d      = r_tx_sr;
    w_miso_d       = r_miso;
    w_rx_data_d    = r_rx_data;
    w_rx_valid_d   = 1'b0;
    w_frame_err_d  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_miso_d    = 1'b0;
        w_bit_cnt_d = '0;
        if (!i_ss_n) begin
          w_state_d = StChkCmd;
        end
      end

      StChkCmd: begin
        if (i_ss_n) begin
          w_state_d     = StIdle;
          w_frame_err_d = 1'b1;
        end else begin
          w_rx_sr_d   = {{(FRAME_W-2){1'b0}}, i_mosi};
          w_bit_cnt_d = ONE_CNT;
          if (!i_mosi) begin
            w_state_d = StWrite;
          end else if (r_rd_pending) begin
            w_state_d = StReadData;
          end else begin
            w_state_d = StReadAdd;
          end
        end
      end

      StWrite, StReadAdd, StReadData: begin
        if (i_ss_n) begin
          w_state_d     = StIdle;
          w_miso_d      = 1'b0;
          w_frame_err_d = (r_bit_cnt != FRAME_CNT);
        end else if (r_bit_cnt != FRAME_CNT) begin
          w_rx_sr_d   = w_frame[FRAME_W-2:0];
          w_bit_cnt_d = r_bit_cnt + ONE_CNT;
          if (r_bit_cnt == LAST_CNT) begin
            w_rx_data_d  = w_rx_word;
            w_rx_valid_d = 1'b1;
            if (r_state == StReadAdd) begin
              w_rd_pending_d = 1'b1;
            end
          end
        end else if (r_state == StReadData && i_tx_valid) begin
          // First payload bit goes out right away; the rest is shifted from r_tx_sr.
          w_state_d   = StTxShift;
          w_bit_cnt_d = ONE_CNT;
          if (LSB_FIRST) begin
            w_miso_d  = i_tx_data[0];
            w_tx_sr_d = {1'b0, i_tx_data[DATA_W-1:1]};
          end else begin
            w_miso_d  = i_tx_data[DATA_W-1];
            w_tx_sr_d = {i_tx_data[DATA_W-2:0], 1'b0};
          end
        end
      end

      StTxShift: begin
        if (i_ss_n) begin
          w_state_d     = StIdle;
          w_miso_d      = 1'b0;
          w_frame_err_d = (r_bit_cnt != DATA_CNT);
          if (r_bit_cnt == DATA_CNT) begin
            w_rd_pending_d = 1'b0;
          end
        end else if (r_bit_cnt != DATA_CNT) begin
          w_bit_cnt_d = r_bit_cnt + ONE_CNT;
          if (LSB_FIRST) begin
            w_miso_d  = r_tx_sr[0];
            w_tx_sr_d = {1'b0, r_tx_sr[DATA_W-1:1]};
          end else begin
            w_miso_d  = r_tx_sr[DATA_W-1];
            w_tx_sr_d = {r_tx_sr[DATA_W-2:0], 1'b0};
          end
        end else begin
          // Last bit has been on the line for a full cycle: read-back is complete.
          w_miso_d       = 1'b0;
          w_rd_pending_d = 1'b0;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_pending <= 1'b0;
      r_bit_cnt    <= '0;
      r_rx_sr      <= '0;
      r_tx_sr      <= '0;
      r_miso       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rd_pending <= w_rd_pending_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_rx_sr      <= w_rx_sr_d;
      r_tx_sr      <= w_tx_sr_d;
      r_miso       <= w_miso_d;
      r_rx_data    <= w_rx_data_d;
      r_rx_valid   <= w_rx_valid_d;
      r_frame_err  <= w_frame_err_d;
    end
  end

  assign o_miso      = r_miso;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_busy      = (r_state != StIdle);
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Scoreboard bench for spi_slave_gen2: one MSB-first and one LSB-first instance.
module tb_spi_slave_gen2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus, routed to the selected instance; the other sees an idle bus.
  logic       sel = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       ss_n0, mosi0, tx_valid0, ss_n1, mosi1, tx_valid1;
  logic       miso0, rx_valid0, busy0, frame_err0;
  logic       miso1, rx_valid1, busy1, frame_err1;
  logic [9:0] rx_data0, rx_data1;

  assign ss_n0     = sel ? 1'b1 : ss_n;
  assign mosi0     = sel ? 1'b0 : mosi;
  assign tx_valid0 = sel ? 1'b0 : tx_valid;
  assign ss_n1     = sel ? ss_n : 1'b1;
  assign mosi1     = sel ? mosi : 1'b0;
  assign tx_valid1 = sel ? tx_valid : 1'b0;

  spi_slave_gen2 #(.DATA_W(8), .LSB_FIRST(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_ss_n(ss_n0), .i_mosi(mosi0), .o_miso(miso0),
    .o_rx_data(rx_data0), .o_rx_valid(rx_valid0), .i_tx_data(tx_data),
    .i_tx_valid(tx_valid0), .o_busy(busy0), .o_frame_err(frame_err0)
  );

  spi_slave_gen2 #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_ss_n(ss_n1), .i_mosi(mosi1), .o_miso(miso1),
    .o_rx_data(rx_data1), .o_rx_valid(rx_valid1), .i_tx_data(tx_data),
    .i_tx_valid(tx_valid1), .o_busy(busy1), .o_frame_err(frame_err1)
  );

  typedef struct packed {
    logic [9:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          ferr0 = 0, ferr1 = 0, rxc0 = 0, rxc1 = 0;
  logic        miso_hi0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever an instance presents rx_valid.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid0 === 1'b1) begin
      rxc0++;
      chk("rx0_expected", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("rx0_data", 32'(rx_data0), 32'(e.data));
        chk("rx0_cycle", cyc, e.cyc);
      end
    end
    if (rx_valid1 === 1'b1) begin
      rxc1++;
      chk("rx1_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("rx1_data", 32'(rx_data1), 32'(e.data));
        chk("rx1_cycle", cyc, e.cyc);
      end
    end
    if (frame_err0 === 1'b1) ferr0++;
    if (frame_err1 === 1'b1) ferr1++;
    if (miso0 === 1'b1) miso_hi0 = 1'b1;
  end

  // Drives the first nbits of a 10-bit frame, MSB (cmd[1]) first; returns at the
  // negedge where the last bit was placed on MOSI.
  task automatic send_frame(input logic [9:0] f, input int nbits);
    @(negedge clk);
    ss_n = 1'b0;
    mosi = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      mosi = f[9-k];
    end
  endtask

  // Full frame; expected word is queued, returns in the rx_valid cycle.
  task automatic send_full(input logic [9:0] f, input logic [9:0] exp);
    exp_t e;
    send_frame(f, 10);
    e.data = exp;
    e.cyc  = cyc + 1;
    if (sel) q1.push_back(e);
    else q0.push_back(e);
    @(negedge clk);
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulses tx_valid and checks the first nbits of MISO; seq holds them in time order.
  task automatic tx_and_check(input logic [7:0] d, input logic [7:0] seq, input int nbits);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int j = 0; j < nbits; j++) begin
      chk($sformatf("miso_bit%0d", j), 32'(sel ? miso1 : miso0), 32'(seq[7-j]));
      if (j < nbits - 1) @(negedge clk);
    end
  endtask

  initial begin
    int f0, r0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(miso0), 32'd0);
    chk("reset_rx_data", 32'(rx_data0), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_frame_err", 32'(frame_err0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write frame 00 + 0xA5.
    miso_hi0 = 1'b0;
    send_full(10'h0A5, 10'h0A5);
    chk("write_pending", 32'(dut.r_rd_pending), 32'd0);
    end_frame();
    chk("write_busy_after", 32'(busy0), 32'd0);
    chk("write_miso_quiet", 32'(miso_hi0), 32'd0);

    // Read pair: address frame then data frame with tx handshake.
    send_full(10'h23C, 10'h23C);
    end_frame();
    chk("readadd_pending", 32'(dut.r_rd_pending), 32'd1);
    send_full(10'h300, 10'h300);
    @(negedge clk);
    @(negedge clk);
    tx_and_check(8'h96, 8'b1001_0110, 8);
    @(negedge clk);
    chk("read_miso_after", 32'(miso0), 32'd0);
    @(negedge clk);
    chk("read_pending_clr", 32'(dut.r_rd_pending), 32'd0);
    end_frame();
    #1;
    chk("no_err_so_far", 32'(ferr0), 32'd0);

    // Abort after 5 frame bits.
    r0 = rxc0;
    f0 = ferr0;
    send_frame(10'h3FF, 5);
    @(negedge clk);
    ss_n = 1'b1;
    @(negedge clk);
    chk("abort_err_pulse", 32'(frame_err0), 32'd1);
    chk("abort_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_err_count", 32'(ferr0 - f0), 32'd1);
    chk("abort_no_rx", 32'(rxc0 - r0), 32'd0);
    chk("abort_rx_hold", 32'(rx_data0), 32'h300);
    send_full(10'h05A, 10'h05A);
    end_frame();

    // Shift-out abort after 3 MISO bits.
    send_full(10'h2AA, 10'h2AA);
    end_frame();
    send_full(10'h355, 10'h355);
    f0 = ferr0;
    tx_and_check(8'hC3, 8'b1100_0011, 3);
    ss_n = 1'b1;
    @(negedge clk);
    chk("txabort_err", 32'(frame_err0), 32'd1);
    chk("txabort_miso", 32'(miso0), 32'd0);
    chk("txabort_pending", 32'(dut.r_rd_pending), 32'd1);
    @(negedge clk);
    send_full(10'h211, 10'h211);
    tx_and_check(8'h80, 8'b1000_0000, 4);

    // Reset in the middle of the shift-out.
    r0 = rxc0;
    #1;
    f0 = ferr0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_miso", 32'(miso0), 32'd0);
    chk("rst_rx_data", 32'(rx_data0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_pending", 32'(dut.r_rd_pending), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid0), 32'd0);
    chk("rst_frame_err", 32'(frame_err0), 32'd0);
    rst  = 1'b0;
    ss_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_no_rx", 32'(rxc0 - r0), 32'd0);
    chk("rst_no_err", 32'(ferr0 - f0), 32'd0);

    // LSB-first instance.
    sel = 1'b1;
    @(negedge clk);
    send_full(10'h0A5, 10'h0A5);
    end_frame();
    send_full(10'h201, 10'h280);
    end_frame();
    send_full(10'h300, 10'h300);
    tx_and_check(8'h01, 8'b1000_0000, 8);
    @(negedge clk);
    chk("lsb_miso_after", 32'(miso1), 32'd0);
    @(negedge clk);
    chk("lsb_pending_clr", 32'(dut_l.r_rd_pending), 32'd0);
    end_frame();
    @(negedge clk);
    #1;
    chk("lsb_no_err", 32'(ferr1), 32'd0);
    chk("lsb_rx_count", 32'(rxc1), 32'd3);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
